ahb_lite_cordic_master: RTL

AHB-Lite single-master engine that drives the CORDIC AHB-Lite slave from a local command stream. Each accepted 32-bit operand produces one AHB write of the operand to the CORDIC slave, then one AHB read of the result. The result is returned on a valid/ready response port. It sits between the local sequencer or test harness and the AHB-Lite bus in front of the CORDIC slave.

---
 rtl/ahb_lite_cordic_master.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/ahb_lite_cordic_master.sv
// AHB-Lite master that writes each operand to the CORDIC slave, then reads back the result.
// Optional data-phase stall timeout is built when CORDIC_MASTER_TIMEOUT_EN is defined.
module ahb_lite_cordic_master #(
    parameter logic [31:0] BASE_ADDR      = 32'h4000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic        HMASTLOCK,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic        HRESP,
    input  logic [31:0] HRDATA,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR_A = 3'd1,
        S_WR_D = 3'd2,
        S_RD_A = 3'd3,
        S_RD_D = 3'd4,
        S_RSP  = 3'd5
    } state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_e      state_q, state_d;
    logic [1:0]  htrans_q, htrans_d;
    logic        hwrite_q, hwrite_d;
    logic [31:0] hwdata_q, hwdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;
    logic        tmo_hit;

`ifdef CORDIC_MASTER_TIMEOUT_EN
    localparam int unsigned CNT_W =
        ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             in_data_phase;

    assign in_data_phase = (state_q == S_WR_D) || (state_q == S_RD_D);
`endif

    always_comb begin
        state_d    = state_q;
        hwdata_d   = hwdata_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        tmo_hit    = 1'b0;

`ifdef CORDIC_MASTER_TIMEOUT_EN
        tmo_hit = in_data_phase && !HREADY && (tmo_cnt_q == TMO_LAST);
`endif

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    hwdata_d = cmd_data;
                    state_d  = S_WR_A;
                end
            end
            S_WR_A: begin
                if (HREADY) begin
                    state_d = S_WR_D;
                end
            end
            S_WR_D: begin
                // HRESP=1 with HREADY=0 is the first half of an error response: just wait.
                if (HREADY) begin
                    if (HRESP) begin
                        state_d    = S_RSP;
                        rsp_err_d  = 1'b1;
                        rsp_data_d = '0;
                    end else begin
                        state_d = S_RD_A;
                    end
                end else if (tmo_hit) begin
                    state_d    = S_RSP;
                    rsp_err_d  = 1'b1;
                    rsp_data_d = '0;
                end
            end
            S_RD_A: begin
                if (HREADY) begin
                    state_d = S_RD_D;
                end
            end
            S_RD_D: begin
                if (HREADY) begin
                    state_d = S_RSP;
                    if (HRESP) begin
                        rsp_err_d  = 1'b1;
                        rsp_data_d = '0;
                    end else begin
                        rsp_err_d  = 1'b0;
                        rsp_data_d = HRDATA;
                    end
                end else if (tmo_hit) begin
                    state_d    = S_RSP;
                    rsp_err_d  = 1'b1;
                    rsp_data_d = '0;
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Bus and response outputs are registered by decoding the next state.
    always_comb begin
        htrans_d    = ((state_d == S_WR_A) || (state_d == S_RD_A)) ? HTRANS_NONSEQ : HTRANS_IDLE;
        hwrite_d    = (state_d == S_WR_A);
        rsp_valid_d = (state_d == S_RSP);
    end

`ifdef CORDIC_MASTER_TIMEOUT_EN
    always_comb begin
        tmo_cnt_d = '0;
        if (in_data_phase && !HREADY && (state_d == state_q)) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`endif

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= S_IDLE;
            htrans_q    <= HTRANS_IDLE;
            hwrite_q    <= 1'b0;
            hwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            htrans_q    <= htrans_d;
            hwrite_q    <= hwrite_d;
            hwdata_q    <= hwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign HADDR     = BASE_ADDR;
    assign HTRANS    = htrans_q;
    assign HWRITE    = hwrite_q;
    assign HSIZE     = 3'b010;
    assign HBURST    = 3'b000;
    assign HPROT     = 4'b0011;
    assign HMASTLOCK = 1'b0;
    assign HWDATA    = hwdata_q;

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);

endmodule
